// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency-meter display stage:
// converter FSM states, digit counts and the 7-segment glyph table.
package freq_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS = 8;
  // Two extra digits hold the part of a 32-bit value beyond 99,999,999.
  localparam int BCD_DIGITS = 10;
  localparam int BIN_W      = 32;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high, decimal point never lit.
  function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Captures the foreign-domain binary count, waits for it to be stable and
// converts it to packed BCD with a 32-step shift-add-3 engine.
module bin2bcd_seq
  import freq_disp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BIN_W-1:0] din_i,
  output logic [31:0]      bcd_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int ACC_W = 4 * BCD_DIGITS;

  conv_state_e      state_q;
  logic [BIN_W-1:0] s1_q;
  logic [BIN_W-1:0] last_q;
  logic [BIN_W-1:0] shift_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_adj;
  logic [4:0]       iter_q;
  logic [31:0]      bcd_q;
  logic             ovf_q;
  logic             busy_q;
  logic             stable;
  logic             start;

  // Two identical consecutive samples reject a count caught mid-update.
  assign stable = (din_i == s1_q);
  assign start  = stable && (s1_q != last_q);

  always_comb begin
    acc_adj = acc_q;
    for (int n = 0; n < BCD_DIGITS; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) begin
        acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s1_q    <= '0;
      last_q  <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q <= din_i;
      case (state_q)
        IDLE: begin
          if (start) begin
            last_q  <= s1_q;
            acc_q   <= '0;
            shift_q <= s1_q;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          acc_q   <= {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
          shift_q <= {shift_q[BIN_W-2:0], 1'b0};
          iter_q  <= iter_q + 5'd1;
          if (iter_q == 5'd31) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= acc_q[31:0];
          ovf_q   <= (acc_q[ACC_W-1:32] != '0);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/freq_disp.sv
// Display stage: binary-to-BCD conversion plus an 8-digit multiplexed
// common-cathode scanner with leading-zero blanking and overflow dashes.
module freq_disp
  import freq_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] DIN,
  output logic [31:0] BCD,
  output logic        OVF,
  output logic        BUSY,
  output logic [7:0]  SEG,
  output logic [7:0]  DIG_SEL
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [31:0]           bcd_w;
  logic                  ovf_w;
  logic                  busy_w;
  logic [CW-1:0]         scan_cnt_q;
  logic [2:0]            dig_idx_q;
  logic [7:0]            seg_q;
  logic [7:0]            seg_d;
  logic [7:0]            dig_sel_q;
  logic [7:0]            dig_sel_d;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [7:0]            digit_seg [NUM_DIGITS];

  bin2bcd_seq u_conv (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .din_i  (DIN),
    .bcd_o  (bcd_w),
    .ovf_o  (ovf_w),
    .busy_o (busy_w)
  );

  // Glyph for every digit position is formed in parallel, then muxed by index.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_units
      assign lead_zero[gi] = 1'b0;
    end else begin : g_upper
      assign lead_zero[gi] = ~|bcd_w[31:4*gi];
    end
    assign digit_seg[gi] = ovf_w         ? SEG_DASH  :
                           lead_zero[gi] ? SEG_BLANK :
                           digit_to_seg(bcd_w[4*gi +: 4]);
  end

  always_comb begin
    seg_d     = digit_seg[dig_idx_q];
    dig_sel_d = ~(8'h01 << dig_idx_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
      seg_q      <= SEG_BLANK;
      dig_sel_q  <= 8'hFF;
    end else begin
      if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        dig_idx_q  <= dig_idx_q + 3'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      // Select and segments come from the same index so they switch together.
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign BCD     = bcd_w;
  assign OVF     = ovf_w;
  assign BUSY    = busy_w;
  assign SEG     = seg_q;
  assign DIG_SEL = dig_sel_q;

endmodule
